// File: rtl/instruction_queue_pkg.sv
// Shared constants and types for the instruction queue.
// The optional previous-instruction output is enabled with `define INSTRUCTION_QUEUE_PREV_EN.
package instruction_queue_pkg;

    localparam int unsigned IQ_IW    = 16;
    localparam int unsigned IQ_DEPTH = 4;
    localparam int unsigned IQ_REGW  = 4;
    localparam int unsigned IQ_OPW   = 4;

    // Opcode that reuses the destination as first source and forces a fixed second source
    localparam logic [3:0] SPECIAL_OP  = 4'b1001;
    localparam logic [3:0] SPECIAL_REG = 4'b1110;

    // Decoded register/opcode fields at default widths
    typedef struct packed {
        logic [IQ_OPW-1:0]  opcode;
        logic [IQ_REGW-1:0] reg_rd;
        logic [IQ_REGW-1:0] reg_1;
        logic [IQ_REGW-1:0] reg_2;
    } ir_fields_t;

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// previous_instruction exists only when INSTRUCTION_QUEUE_PREV_EN is defined.
interface instruction_queue_if
    import instruction_queue_pkg::*;
#(
    parameter int unsigned IW    = IQ_IW,
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned REGW  = IQ_REGW,
    parameter int unsigned OPW   = IQ_OPW
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_instruction;
    logic            issue;
    logic            flush;
    logic            out_valid;
    logic [IW-1:0]   out_instruction;
    logic [OPW-1:0]  out_opcode;
    logic [REGW-1:0] out_RegRd;
    logic [REGW-1:0] out_Reg1;
    logic [REGW-1:0] out_Reg2;
    logic [CW-1:0]   count;
`ifdef INSTRUCTION_QUEUE_PREV_EN
    logic [IW-1:0]   previous_instruction;
`endif

    // Fetch/decode side
    modport master (
        output in_valid, in_instruction, issue, flush,
`ifdef INSTRUCTION_QUEUE_PREV_EN
        input  previous_instruction,
`endif
        input  in_ready, out_valid, out_instruction, out_opcode,
        input  out_RegRd, out_Reg1, out_Reg2, count
    );

    // Queue side
    modport slave (
        input  in_valid, in_instruction, issue, flush,
`ifdef INSTRUCTION_QUEUE_PREV_EN
        output previous_instruction,
`endif
        output in_ready, out_valid, out_instruction, out_opcode,
        output out_RegRd, out_Reg1, out_Reg2, count
    );

endinterface

// File: rtl/ir_field_decode.sv
// Combinational register/opcode field extraction for one instruction word.
module ir_field_decode
    import instruction_queue_pkg::*;
#(
    parameter int unsigned IW   = IQ_IW,
    parameter int unsigned REGW = IQ_REGW,
    parameter int unsigned OPW  = IQ_OPW
)(
    input  logic [IW-1:0]   instruction,
    output logic [OPW-1:0]  opcode_c,
    output logic [REGW-1:0] reg_rd_c,
    output logic [REGW-1:0] reg_1_c,
    output logic [REGW-1:0] reg_2_c
);

    // Plain field slicing, overridden for the special opcode
    always_comb begin
        opcode_c = instruction[OPW-1:0];
        reg_rd_c = instruction[IW-1 -: REGW];
        reg_1_c  = instruction[IW-REGW-1 -: REGW];
        reg_2_c  = instruction[IW-2*REGW-1 -: REGW];
        if (instruction[OPW-1:0] == OPW'(SPECIAL_OP)) begin
            reg_1_c = instruction[IW-1 -: REGW];
            reg_2_c = REGW'(SPECIAL_REG);
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// Circular FIFO of fetched instructions with fields decoded on enqueue.
// Define INSTRUCTION_QUEUE_PREV_EN to add the previous_instruction output.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int unsigned IW    = IQ_IW,
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned REGW  = IQ_REGW,
    parameter int unsigned OPW   = IQ_OPW
)(
    input  logic               CLK,
    input  logic               RST_N,
    instruction_queue_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Reject configurations the field map or pointer wrap cannot support
    if (IW < OPW + 3*REGW) begin : g_bad_width
        $error("instruction_queue: IW must be at least OPW+3*REGW");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_queue: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    logic [IW-1:0]   instr_mem [DEPTH];
    logic [OPW-1:0]  op_mem    [DEPTH];
    logic [REGW-1:0] rd_mem    [DEPTH];
    logic [REGW-1:0] r1_mem    [DEPTH];
    logic [REGW-1:0] r2_mem    [DEPTH];

    logic [OPW-1:0]  dec_opcode_c;
    logic [REGW-1:0] dec_rd_c;
    logic [REGW-1:0] dec_r1_c;
    logic [REGW-1:0] dec_r2_c;

    logic            out_valid_c;
    logic            push_c;
    logic            pop_c;

    assign out_valid_c = (count_q != '0);
    assign push_c      = bus.in_valid && bus.in_ready;
    // A flush wins over issue, so the head is not consumed in that cycle
    assign pop_c       = bus.issue && out_valid_c && !bus.flush;

    ir_field_decode #(.IW(IW), .REGW(REGW), .OPW(OPW)) u_decode (
        .instruction (bus.in_instruction),
        .opcode_c    (dec_opcode_c),
        .reg_rd_c    (dec_rd_c),
        .reg_1_c     (dec_r1_c),
        .reg_2_c     (dec_r2_c)
    );

    // Pointer and occupancy tracking; flush empties the queue
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Entry storage; contents are masked at the output while empty
    always_ff @(posedge CLK) begin
        if (push_c && !bus.flush) begin
            instr_mem[wr_ptr] <= bus.in_instruction;
            op_mem[wr_ptr]    <= dec_opcode_c;
            rd_mem[wr_ptr]    <= dec_rd_c;
            r1_mem[wr_ptr]    <= dec_r1_c;
            r2_mem[wr_ptr]    <= dec_r2_c;
        end
    end

`ifdef INSTRUCTION_QUEUE_PREV_EN
    logic [IW-1:0] prev_q;

    // Remember the most recently issued word
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_q <= '0;
        end else if (pop_c) begin
            prev_q <= instr_mem[rd_ptr];
        end
    end

    assign bus.previous_instruction = prev_q;
`endif

    assign bus.in_ready        = (count_q < CW'(DEPTH));
    assign bus.count           = count_q;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_instruction = out_valid_c ? instr_mem[rd_ptr] : '0;
    assign bus.out_opcode      = out_valid_c ? op_mem[rd_ptr]    : '0;
    assign bus.out_RegRd       = out_valid_c ? rd_mem[rd_ptr]    : '0;
    assign bus.out_Reg1        = out_valid_c ? r1_mem[rd_ptr]    : '0;
    assign bus.out_Reg2        = out_valid_c ? r2_mem[rd_ptr]    : '0;

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter IW, default 16: instruction width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; SHALL be a power of two and at least 2.
REQ-003 Parameter REGW, default 4: register-specifier width.
REQ-004 Parameter OPW, default 4: opcode width; IW SHALL be at least OPW+3*REGW (elaboration error otherwise).
REQ-005 CLK  in  1  single clock, all state updates on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  fetch side offers in_instruction.
REQ-008 in_ready  out  1  queue accepts; SHALL equal (count < DEPTH), with no dependence on issue.
REQ-009 in_instruction  in  IW  fetched instruction word.
REQ-010 issue  in  1  decode stage consumes the head entry.
REQ-011 flush  in  1  discard all queued entries (branch/jump redirect).
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_instruction  out  IW  head instruction word.
REQ-014 out_opcode  out  OPW  bits [OPW-1:0] of the head entry.
REQ-015 out_RegRd, out_Reg1, out_Reg2  out  REGW each  decoded register specifiers of the head entry.
REQ-016 count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Field map: RegRd=[IW-1:IW-REGW], Reg1=next REGW bits down, Reg2=next REGW bits down, opcode=[OPW-1:0].
REQ-018 If the opcode equals SPECIAL_OP (4'b1001), Reg1 SHALL be the RegRd field and Reg2 SHALL be SPECIAL_REG (4'b1110); otherwise fields follow REQ-017.
REQ-019 Decoding SHALL occur at enqueue; decoded fields SHALL be stored per entry and remain stable while the entry is queued.
REQ-020 A push occurs when in_valid and in_ready are both high; a pop occurs when issue and out_valid are both high; issue while empty SHALL be ignored.
REQ-021 Latency: a word pushed into an empty queue SHALL appear on out_* with out_valid=1 on the following cycle.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when count=1; the new head is the next-older entry.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-024 While out_valid=0, out_instruction and all decoded outputs SHALL be zero.
REQ-025 flush SHALL set count and both pointers to 0 at the next edge and SHALL take priority over push and pop in the same cycle; the offered word is dropped.

Reset
REQ-026 RST_N low SHALL immediately clear count, pointers, out_valid, all out_* fields and previous_instruction to zero, including mid-transfer; in_ready SHALL be 1 after reset.

Configuration
REQ-027 Macro INSTRUCTION_QUEUE_PREV_EN: when defined, output previous_instruction (IW) SHALL load the current out_instruction on each pop, hold otherwise, and be unaffected by flush; when undefined, the port and its register SHALL be absent.

Structure
REQ-028 Package instruction_queue_pkg SHALL hold the default widths, SPECIAL_OP and SPECIAL_REG constants and the decoded-fields struct typedef.
REQ-029 Combinational sub-module ir_field_decode SHALL implement REQ-017/018 and be instantiated once on the write path.

Verification
REQ-030 Push 16'h3A51 into empty queue -> next cycle out_valid=1, opcode=1, RegRd=3, Reg1=A, Reg2=5, count=1.
REQ-031 Push 16'h7009 -> Reg1=7, Reg2=E, RegRd=7, opcode=9.
REQ-032 Push 4 words without issue -> count=4, in_ready=0; 5th offered word is not stored; 4 issues return words in order, then out_valid=0 and outputs zero.
REQ-033 Continuous push+issue for 10 cycles at count=2 -> count stays 2, FIFO order preserved across pointer wrap.
REQ-034 count=3 with push, issue and flush together -> next cycle count=0, out_valid=0; with macro, previous_instruction is unchanged.
REQ-035 Assert RST_N low mid-stream between edges -> all outputs zero immediately; with macro, previous_instruction=0.
